// File: rtl/cpu_bus_seq.sv
// cpu_bus_seq: M-cycle bus sequencer between the CPU core and the external bus.
// Expands one M-cycle request (internal, read, write, opcode fetch) into the
// T-states T1..T4, drives adr/dout/rd/wr, latches din into mdin and flags mdone.
// Optional feature: define CPU_BUS_SEQ_WAIT_EN to add the ready input, which
// stretches T3 until the external device is ready.
module cpu_bus_seq #(
    parameter int ADR_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 mreq,
    input  logic [1:0]           mtype,
    input  logic [ADR_WIDTH-1:0] madr,
    input  logic [7:0]           mdout,
    output logic [7:0]           mdin,
    output logic                 mdone,
    output logic [1:0]           tstate,
    output logic                 idle,
    output logic                 m1,
    output logic [ADR_WIDTH-1:0] adr,
    output logic [7:0]           dout,
    input  logic [7:0]           din,
`ifdef CPU_BUS_SEQ_WAIT_EN
    input  logic                 ready,
`endif
    output logic                 rd,
    output logic                 wr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_T1,
        S_T2,
        S_T3,
        S_T4
    } state_e;

    typedef enum logic [1:0] {
        MT_INT   = 2'b00,
        MT_RD    = 2'b01,
        MT_WR    = 2'b10,
        MT_FETCH = 2'b11
    } mtype_e;

    state_e                 state_q, state_d;
    mtype_e                 type_q, type_d;
    logic [ADR_WIDTH-1:0]   adr_q, adr_d;
    logic [7:0]             dout_q, dout_d;
    logic [7:0]             mdin_q, mdin_d;
    logic                   rd_q, rd_d;
    logic                   wr_q, wr_d;
    logic                   m1_q, m1_d;
    logic                   mdone_q, mdone_d;
    logic [1:0]             tstate_q, tstate_d;
    logic                   idle_q, idle_d;

    logic                   start;
    logic                   t3_stall;
    logic                   is_rd_next;
    logic                   is_wr_next;

`ifdef CPU_BUS_SEQ_WAIT_EN
    assign t3_stall = ~ready;
`else
    assign t3_stall = 1'b0;
`endif

    // A new M-cycle is accepted only from IDLE or at the end of T4.
    assign start = mreq && ((state_q == S_IDLE) || (state_q == S_T4));

    // State and registered outputs; reset aborts a cycle and drops rd/wr at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: every flop here has a defined reset value, including the
            // datapath registers, because adr/dout/mdin are visible outputs.
            state_q  <= S_IDLE;
            type_q   <= MT_INT;
            adr_q    <= '0;
            dout_q   <= '0;
            mdin_q   <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            m1_q     <= 1'b0;
            mdone_q  <= 1'b0;
            tstate_q <= 2'd0;
            idle_q   <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments so all flops update from the
            // same pre-edge values regardless of statement order.
            state_q  <= state_d;
            type_q   <= type_d;
            adr_q    <= adr_d;
            dout_q   <= dout_d;
            mdin_q   <= mdin_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            m1_q     <= m1_d;
            mdone_q  <= mdone_d;
            tstate_q <= tstate_d;
            idle_q   <= idle_d;
        end
    end

    // Next-state logic: T1..T3 ignore mreq; T3 may stall on ready.
    always_comb begin
        // NOTE: default first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (mreq) state_d = S_T1;
            S_T1:   state_d = S_T2;
            S_T2:   state_d = S_T3;
            S_T3:   if (!t3_stall) state_d = S_T4;
            S_T4:   state_d = mreq ? S_T1 : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Request capture on entry to T1 and read-data latch on the edge leaving T3.
    always_comb begin
        type_d = type_q;
        adr_d  = adr_q;
        dout_d = dout_q;
        mdin_d = mdin_q;
        if (start) begin
            type_d = mtype_e'(mtype);
            if (mtype_e'(mtype) != MT_INT) adr_d = madr;
            if (mtype_e'(mtype) == MT_WR) dout_d = mdout;
        end
        if ((state_q == S_T3) && !t3_stall &&
            ((type_q == MT_RD) || (type_q == MT_FETCH))) begin
            mdin_d = din;
        end
    end

    assign is_rd_next = (type_d == MT_RD) || (type_d == MT_FETCH);
    assign is_wr_next = (type_d == MT_WR);

    // Output decode from the next state so strobes and status come from flops.
    always_comb begin
        rd_d     = 1'b0;
        wr_d     = 1'b0;
        m1_d     = 1'b0;
        mdone_d  = 1'b0;
        tstate_d = 2'd0;
        idle_d   = 1'b0;
        unique case (state_d)
            S_IDLE: idle_d = 1'b1;
            S_T1: begin
                tstate_d = 2'd0;
                rd_d     = is_rd_next;
                m1_d     = (type_d == MT_FETCH);
            end
            S_T2: begin
                tstate_d = 2'd1;
                rd_d     = is_rd_next;
                wr_d     = is_wr_next;
                m1_d     = (type_d == MT_FETCH);
            end
            S_T3: begin
                tstate_d = 2'd2;
                rd_d     = is_rd_next;
                wr_d     = is_wr_next;
                m1_d     = (type_d == MT_FETCH);
            end
            S_T4: begin
                tstate_d = 2'd3;
                m1_d     = (type_d == MT_FETCH);
                mdone_d  = 1'b1;
            end
            default: idle_d = 1'b1;
        endcase
    end

    assign adr    = adr_q;
    assign dout   = dout_q;
    assign mdin   = mdin_q;
    assign rd     = rd_q;
    assign wr     = wr_q;
    assign m1     = m1_q;
    assign mdone  = mdone_q;
    assign tstate = tstate_q;
    assign idle   = idle_q;

endmodule

// File: tb/tb_cpu_bus_seq.sv
// tb_cpu_bus_seq: directed, scoreboard-based bench for cpu_bus_seq.
// Expected (adr, mdin, m1) per M-cycle are queued when the request is driven
// and popped when mdone is observed. Outputs are sampled 1 time unit after
// the rising edge. Stall steps are compiled in with CPU_BUS_SEQ_WAIT_EN.
module tb_cpu_bus_seq;

    typedef struct {
        logic [15:0] adr;
        logic [7:0]  data;
        logic        m1;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mreq;
    logic [1:0]  mtype;
    logic [15:0] madr;
    logic [7:0]  mdout;
    logic [7:0]  mdin;
    logic        mdone;
    logic [1:0]  tstate;
    logic        idle;
    logic        m1;
    logic [15:0] adr;
    logic [7:0]  dout;
    logic [7:0]  din;
    logic        ready;
    logic        rd;
    logic        wr;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb[$];
    exp_t cur;
    exp_t got;

    cpu_bus_seq #(.ADR_WIDTH(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .mreq    (mreq),
        .mtype   (mtype),
        .madr    (madr),
        .mdout   (mdout),
        .mdin    (mdin),
        .mdone   (mdone),
        .tstate  (tstate),
        .idle    (idle),
        .m1      (m1),
        .adr     (adr),
        .dout    (dout),
        .din     (din),
`ifdef CPU_BUS_SEQ_WAIT_EN
        .ready   (ready),
`endif
        .rd      (rd),
        .wr      (wr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Pops the scoreboard entry for the cycle that just signalled mdone.
    task automatic sb_pop_compare(input string tag);
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL %s_sb_empty observed=0 expected=1", tag);
        end
        if (sb.size() > 0) begin
            got = sb.pop_front();
            check({tag, "_mdin"}, {24'd0, mdin}, {24'd0, got.data});
            check({tag, "_adr"}, {16'd0, adr}, {16'd0, got.adr});
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [15:0] seq_adr[3];
        logic [7:0]  seq_din[3];
        int          last_done;
        int          wr_cnt;
        int          clocks;

        seq_adr = '{16'h0150, 16'h0151, 16'h0152};
        seq_din = '{8'hFA, 8'h34, 8'h12};

        reset_n = 1'b0;
        mreq    = 1'b0;
        mtype   = 2'b00;
        madr    = 16'h0000;
        mdout   = 8'h00;
        din     = 8'h00;
        ready   = 1'b1;
        repeat (3) tick();
        reset_n = 1'b1;

        // Step 1: idle after reset for 10 clocks.
        for (int i = 0; i < 10; i++) begin
            tick();
            check("rst_idle", {31'd0, idle}, 32'd1);
            check("rst_rdwr", {30'd0, rd, wr}, 32'd0);
            check("rst_adr", {16'd0, adr}, 32'd0);
            check("rst_mdin", {24'd0, mdin}, 32'd0);
        end
        check("rst_tstate", {30'd0, tstate}, 32'd0);

        // Step 2: fetch 0x0150 then reads 0x0151, 0x0152 back to back.
        mreq  = 1'b1;
        mtype = 2'b11;
        madr  = seq_adr[0];
        sb.push_back('{seq_adr[0], seq_din[0], 1'b1});
        last_done = -1;
        for (int c = 0; c < 3; c++) begin
            for (int t = 0; t < 4; t++) begin
                tick();
                if (t == 0) begin
                    cur = sb[0];
                    din = seq_din[c];
                    if (c < 2) begin
                        mtype = 2'b01;
                        madr  = seq_adr[c+1];
                        sb.push_back('{seq_adr[c+1], seq_din[c+1], 1'b0});
                    end else begin
                        mreq = 1'b0;
                    end
                end
                check("seq_tstate", {30'd0, tstate}, t);
                check("seq_adr", {16'd0, adr}, {16'd0, cur.adr});
                check("seq_m1", {31'd0, m1}, {31'd0, cur.m1});
                check("seq_rd", {31'd0, rd}, {31'd0, (t < 3)});
                check("seq_wr", {31'd0, wr}, 32'd0);
                check("seq_idle", {31'd0, idle}, 32'd0);
                check("seq_mdone", {31'd0, mdone}, {31'd0, (t == 3)});
                if (mdone) begin
                    sb_pop_compare("seq");
                    if (last_done >= 0) check("seq_spacing", cyc - last_done, 32'd4);
                    last_done = cyc;
                end
            end
        end
        tick();
        check("seq_end_idle", {31'd0, idle}, 32'd1);
        check("seq_end_rd", {31'd0, rd}, 32'd0);
        check("seq_end_m1", {31'd0, m1}, 32'd0);
        check("seq_end_adr", {16'd0, adr}, 32'h0152);

        // Step 3: write 0xFF80 / 0x5A, then an internal cycle.
        mreq  = 1'b1;
        mtype = 2'b10;
        madr  = 16'hFF80;
        mdout = 8'h5A;
        sb.push_back('{16'hFF80, 8'h12, 1'b0});
        wr_cnt = 0;
        for (int t = 0; t < 4; t++) begin
            tick();
            if (t == 0) begin
                mtype = 2'b00;
                madr  = 16'h1234;
                mdout = 8'h99;
                sb.push_back('{16'hFF80, 8'h12, 1'b0});
            end
            wr_cnt += int'(wr);
            check("wr_tstate", {30'd0, tstate}, t);
            check("wr_adr", {16'd0, adr}, 32'hFF80);
            check("wr_dout", {24'd0, dout}, 32'h5A);
            check("wr_wr", {31'd0, wr}, {31'd0, (t == 1 || t == 2)});
            check("wr_rd", {31'd0, rd}, 32'd0);
            check("wr_mdone", {31'd0, mdone}, {31'd0, (t == 3)});
            if (mdone) sb_pop_compare("wr");
        end
        check("wr_high_clocks", wr_cnt, 32'd2);
        for (int t = 0; t < 4; t++) begin
            tick();
            if (t == 0) mreq = 1'b0;
            check("int_tstate", {30'd0, tstate}, t);
            check("int_adr", {16'd0, adr}, 32'hFF80);
            check("int_rdwr", {30'd0, rd, wr}, 32'd0);
            check("int_m1", {31'd0, m1}, 32'd0);
            check("int_mdone", {31'd0, mdone}, {31'd0, (t == 3)});
            if (mdone) sb_pop_compare("int");
        end
        tick();
        check("int_end_idle", {31'd0, idle}, 32'd1);

        // Step 4: reset during T2 of a read, then a normal read.
        mreq  = 1'b1;
        mtype = 2'b01;
        madr  = 16'h2000;
        din   = 8'h66;
        tick();
        mreq = 1'b0;
        tick();
        check("abort_pre_rd", {31'd0, rd}, 32'd1);
        check("abort_pre_tstate", {30'd0, tstate}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("abort_rd", {31'd0, rd}, 32'd0);
        check("abort_wr", {31'd0, wr}, 32'd0);
        check("abort_idle", {31'd0, idle}, 32'd1);
        check("abort_tstate", {30'd0, tstate}, 32'd0);
        check("abort_adr", {16'd0, adr}, 32'd0);
        check("abort_mdin", {24'd0, mdin}, 32'd0);
        check("abort_m1_mdone", {30'd0, m1, mdone}, 32'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        check("abort_after_idle", {31'd0, idle}, 32'd1);
        check("abort_after_mdin", {24'd0, mdin}, 32'd0);

        mreq  = 1'b1;
        mtype = 2'b01;
        madr  = 16'h3000;
        din   = 8'hC3;
        sb.push_back('{16'h3000, 8'hC3, 1'b0});
        for (int t = 0; t < 4; t++) begin
            tick();
            if (t == 0) mreq = 1'b0;
            check("rec_tstate", {30'd0, tstate}, t);
            check("rec_adr", {16'd0, adr}, 32'h3000);
            check("rec_rd", {31'd0, rd}, {31'd0, (t < 3)});
            check("rec_mdone", {31'd0, mdone}, {31'd0, (t == 3)});
            if (mdone) sb_pop_compare("rec");
        end
        tick();
        check("rec_end_idle", {31'd0, idle}, 32'd1);

`ifdef CPU_BUS_SEQ_WAIT_EN
        // Step 5: read 0xC000 with ready low for 3 clocks in T3.
        mreq  = 1'b1;
        mtype = 2'b01;
        madr  = 16'hC000;
        din   = 8'h77;
        sb.push_back('{16'hC000, 8'h77, 1'b0});
        tick();
        clocks = 1;
        mreq = 1'b0;
        tick();
        clocks++;
        tick();
        clocks++;
        check("stall_t3", {30'd0, tstate}, 32'd2);
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            clocks++;
            check("stall_tstate", {30'd0, tstate}, 32'd2);
            check("stall_rd", {31'd0, rd}, 32'd1);
            check("stall_adr", {16'd0, adr}, 32'hC000);
            check("stall_mdin", {24'd0, mdin}, 32'hC3);
            check("stall_mdone", {31'd0, mdone}, 32'd0);
        end
        ready = 1'b1;
        tick();
        clocks++;
        check("stall_t4", {30'd0, tstate}, 32'd3);
        check("stall_done", {31'd0, mdone}, 32'd1);
        check("stall_rd_off", {31'd0, rd}, 32'd0);
        check("stall_len", clocks, 32'd7);
        if (mdone) sb_pop_compare("stall");
        tick();
        check("stall_end_idle", {31'd0, idle}, 32'd1);
`endif

        check("sb_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_bus_seq.md
# cpu_bus_seq

Machine-cycle bus sequencer between the CPU core and the external memory bus. Turns one M-cycle request (fetch, read, write or internal) into the four T-states T1..T4. It drives the address, read/write strobes and write data, samples read data, and hands the result back to the core. Instruction fetch and operand/immediate reads all pass through this block, so it is directly upstream of the core's decode and execute stages.

## Interface
Parameters:
- ADR_WIDTH, 16, width of address bus

Ports:
- clk  in  1  system clock, one T-state per rising edge
- reset_n  in  1  asynchronous, active-low reset
- mreq  in  1  core requests an M-cycle; sampled in IDLE and in T4
- mtype  in  2  00 internal, 01 read, 10 write, 11 opcode fetch
- madr  in  ADR_WIDTH  address for the requested cycle
- mdout  in  8  write data for a write cycle
- mdin  out  8  last read/fetch data latched from din
- mdone  out  1  high during T4 of every completed M-cycle
- tstate  out  2  current T-state, 0=T1 .. 3=T4; 0 while idle
- idle  out  1  high when no M-cycle is in progress
- m1  out  1  high during T1..T4 of an opcode fetch
- adr  out  ADR_WIDTH  external address
- dout  out  8  external write data
- din  in  8  external read data
- rd  out  1  external read strobe
- wr  out  1  external write strobe
- ready  in  1  external wait input; present only with CPU_BUS_SEQ_WAIT_EN

## Operation
- States: IDLE, T1, T2, T3, T4.
- Transitions:
  - IDLE→T1 when mreq=1.
  - T1→T2→T3→T4 unconditionally. T3 may stall; see Configuration.
  - T4→T1 when mreq=1, otherwise T4→IDLE.
- Request capture: mtype, madr and mdout are captured on the edge entering T1. Changes on these inputs during the cycle are ignored.
- mreq is ignored in T1..T3.
- adr is driven from the captured address from T1 through T4. Internal cycles do not update adr; it keeps its previous value.
- Read and fetch: rd=1 in T1..T3. din is latched into mdin on the edge leaving T3.
- Write: dout = captured mdout from T1 onward. wr=1 in T2..T3 only.
- Internal cycles: rd=0, wr=0, mdin unchanged.
- mdin holds its value until the next read or fetch completes. Write and internal cycles never alter it.
- Reset values: state IDLE, adr=0, dout=0, mdin=0, rd=0, wr=0, m1=0, mdone=0, tstate=0, idle=1.
- Reset asserted mid-cycle aborts the cycle immediately: rd and wr drop asynchronously. No partial result reaches mdin.

## Timing
- Back-to-back cycles take exactly 4 clocks each, with no idle gap when mreq=1 in T4.
- From IDLE, latency is 5 clocks. Request seen at edge k gives T1 in cycle k+1 and mdone in cycle k+4. mdin is valid from cycle k+4.
- rd, wr, m1, mdone, tstate and idle are registered outputs and glitch-free.
- A write cycle's wr deasserts one edge before adr or dout change.

## Configuration
- CPU_BUS_SEQ_WAIT_EN defined:
  - The ready port exists.
  - In T3, if ready=0 the sequencer stays in T3 with rd/wr, adr and dout held and tstate=2.
  - The din sample and the T3→T4 move happen on the first edge with ready=1.
  - Reset during a stall returns to IDLE.
- Macro undefined:
  - No ready port.
  - T3 always lasts one clock.
  - Timing is fixed at 4 clocks per M-cycle.

## Test plan
- Reset released, mreq=0 for 10 clocks -> idle=1, rd=wr=0, adr=0, mdin=0 throughout.
- Fetch at madr=0x0150 with din=0xFA, then reads at 0x0151 (din=0x34) and 0x0152 (din=0x12), mreq held -> m1=1 only in the first cycle. adr sequence is 0x0150/0x0151/0x0152, each held for 4 clocks. mdin is 0xFA, 0x34, 0x12 at the successive mdone pulses, spaced exactly 4 clocks apart.
- Write to 0xFF80 with mdout=0x5A, followed by an internal cycle -> wr high for exactly 2 clocks (T2, T3) with dout=0x5A. adr stays 0xFF80 during the internal cycle. mdin unchanged.
- Reset asserted during T2 of a read -> rd low in the same clock. The block returns to IDLE with all outputs at reset values. The next read completes normally.
- With CPU_BUS_SEQ_WAIT_EN, ready=0 for 3 clocks during a read of 0xC000 (din=0x77) -> the cycle lasts 7 clocks, mdin=0x77, and rd stays high through the stall.
